// File: rtl/lorenz_key_sequencer.sv
// Sequences the Lorenz chaos core: param latch, core reset, warm-up, key harvest.
// Optional Von Neumann debiasing of harvested bits: LORENZ_KEY_VON_NEUMANN_EN.
module lorenz_key_sequencer #(
    parameter int KEY_WIDTH     = 128,
    parameter int WARMUP_CYCLES = 1024,
    parameter int SAMPLE_STRIDE = 4,
    parameter int BIT_SEL       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          sigma_in,
    input  logic [31:0]          rho_in,
    input  logic [31:0]          beta_in,
    input  logic [31:0]          x_in,
    input  logic [31:0]          y_in,
    input  logic [31:0]          z_in,
    output logic [31:0]          sigma_out,
    output logic [31:0]          rho_out,
    output logic [31:0]          beta_out,
    output logic                 core_reset,
    output logic                 busy,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic                 err
);

    localparam int WW = $clog2(WARMUP_CYCLES) + 1;
    localparam int SW = $clog2(SAMPLE_STRIDE) + 1;
    localparam int KW = $clog2(KEY_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        WARMUP,
        HARVEST,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WW-1:0]        wcnt;
    logic [SW-1:0]        scnt;
    logic [KW-1:0]        bcnt;
    logic [95:0]          prev;
    logic                 have_prev;
    logic [KEY_WIDTH-1:0] key_q;
    logic [31:0]          sigma_q;
    logic [31:0]          rho_q;
    logic [31:0]          beta_q;
    logic                 core_reset_q;
    logic                 busy_q;
    logic                 key_valid_q;
    logic                 err_q;
`ifdef LORENZ_KEY_VON_NEUMANN_EN
    logic                 half;
    logic                 first;
`endif

    logic [95:0] triple;
    logic        accept;
    logic        handshake;
    logic        sample;
    logic        stuck;
    logic        raw;
    logic        emit;
    logic        ebit;
    logic        last;
    logic        core_reset_d;
    logic        busy_d;
    logic        key_valid_d;
    logic        err_d;

    assign triple = {x_in, y_in, z_in};

    always_comb begin
        accept    = (state == IDLE) && start;
        handshake = (state == DONE) && key_valid_q && key_ready;
        sample    = (state == HARVEST) && (scnt == '0);
        stuck     = sample && have_prev && (triple == prev);
        raw       = x_in[BIT_SEL] ^ y_in[BIT_SEL] ^ z_in[BIT_SEL];
`ifdef LORENZ_KEY_VON_NEUMANN_EN
        // Only the second bit of an unequal pair emits; the first bit is the value.
        emit      = sample && !stuck && half && (first != raw);
        ebit      = first;
`else
        emit      = sample && !stuck;
        ebit      = raw;
`endif
        last      = emit && (bcnt == KW'(KEY_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (accept) next_state = CORE_RST;
            CORE_RST: if (wcnt == WW'(1)) next_state = WARMUP;
            WARMUP:   if (wcnt == WW'(WARMUP_CYCLES - 1)) next_state = HARVEST;
            HARVEST: begin
                if (stuck) begin
                    next_state = IDLE;
                end else if (last) begin
                    next_state = DONE;
                end
            end
            DONE:     if (handshake) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Core runs only while warming up or harvesting; a stuck core is parked at once.
    always_comb begin
        core_reset_d = 1'b1;
        if (state == WARMUP) begin
            core_reset_d = 1'b0;
        end else if (state == HARVEST) begin
            core_reset_d = stuck;
        end
        key_valid_d = (state == DONE) && !handshake;
        busy_d      = accept || (busy_q && !stuck && !handshake);
        err_d       = stuck || (err_q && !accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt         <= '0;
            scnt         <= '0;
            bcnt         <= '0;
            prev         <= '0;
            have_prev    <= 1'b0;
            key_q        <= '0;
            sigma_q      <= '0;
            rho_q        <= '0;
            beta_q       <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            key_valid_q  <= 1'b0;
            err_q        <= 1'b0;
`ifdef LORENZ_KEY_VON_NEUMANN_EN
            half         <= 1'b0;
            first        <= 1'b0;
`endif
        end else begin
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            key_valid_q  <= key_valid_d;
            err_q        <= err_d;
            if (accept) begin
                sigma_q   <= sigma_in;
                rho_q     <= rho_in;
                beta_q    <= beta_in;
                key_q     <= '0;
                wcnt      <= '0;
                bcnt      <= '0;
                have_prev <= 1'b0;
`ifdef LORENZ_KEY_VON_NEUMANN_EN
                half      <= 1'b0;
`endif
            end
            if (state == CORE_RST) begin
                wcnt <= (wcnt == WW'(1)) ? '0 : wcnt + WW'(1);
            end
            if (state == WARMUP) begin
                wcnt <= wcnt + WW'(1);
                scnt <= '0;
            end
            if (state == HARVEST) begin
                scnt <= (scnt == SW'(SAMPLE_STRIDE - 1)) ? '0 : scnt + SW'(1);
            end
            if (sample && !stuck) begin
                prev      <= triple;
                have_prev <= 1'b1;
`ifdef LORENZ_KEY_VON_NEUMANN_EN
                half      <= !half;
                if (!half) first <= raw;
`endif
            end
            if (emit) begin
                key_q <= {key_q[KEY_WIDTH-2:0], ebit};
                bcnt  <= bcnt + KW'(1);
            end
            if (stuck) begin
                key_q <= '0;
            end
        end
    end

    assign sigma_out  = sigma_q;
    assign rho_out    = rho_q;
    assign beta_out   = beta_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign key_out    = key_q;
    assign key_valid  = key_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lorenz_key_sequencer.sv
// Scoreboard bench for lorenz_key_sequencer with a table-driven core model.
module tb_lorenz_key_sequencer;

    localparam int K     = 8;
    localparam int W     = 4;
    localparam int S     = 2;
    localparam int B     = 0;
    localparam int DEPTH = 1024;

    typedef struct {
        bit         is_err;
        logic [K-1:0] key;
        logic [31:0]  sigma;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [31:0]  sigma_in;
    logic [31:0]  rho_in;
    logic [31:0]  beta_in;
    logic [31:0]  x_in;
    logic [31:0]  y_in;
    logic [31:0]  z_in;
    logic [31:0]  sigma_out;
    logic [31:0]  rho_out;
    logic [31:0]  beta_out;
    logic         core_reset;
    logic         busy;
    logic [K-1:0] key_out;
    logic         key_valid;
    logic         key_ready;
    logic         err;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    logic [31:0] xs [0:DEPTH-1];
    logic [31:0] ys [0:DEPTH-1];
    logic [31:0] zs [0:DEPTH-1];
    int          c = 0;

    lorenz_key_sequencer #(
        .KEY_WIDTH    (K),
        .WARMUP_CYCLES(W),
        .SAMPLE_STRIDE(S),
        .BIT_SEL      (B)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sigma_in  (sigma_in),
        .rho_in    (rho_in),
        .beta_in   (beta_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .sigma_out (sigma_out),
        .rho_out   (rho_out),
        .beta_out  (beta_out),
        .core_reset(core_reset),
        .busy      (busy),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: c counts clocks the core has run since its last reset.
    always @(posedge clk) begin
        if (core_reset) c <= 0;
        else if (c < DEPTH - 1) c <= c + 1;
    end
    assign x_in = xs[c];
    assign y_in = ys[c];
    assign z_in = zs[c];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample k is taken from core cycle W-1+k*S; key bits fill from the LSB.
    function automatic void model(output bit is_err, output logic [K-1:0] key);
        logic [95:0] t;
        logic [95:0] p;
        int nbits;
        bit half;
        bit first;
        bit raw;
        key = '0;
        is_err = 1'b0;
        nbits = 0;
        half = 1'b0;
        first = 1'b0;
        p = '0;
        for (int k = 0; W - 1 + k * S < DEPTH; k++) begin
            int ci;
            ci = W - 1 + k * S;
            t = {xs[ci], ys[ci], zs[ci]};
            if (k > 0 && t == p) begin
                is_err = 1'b1;
                return;
            end
            p = t;
            raw = xs[ci][B] ^ ys[ci][B] ^ zs[ci][B];
`ifdef LORENZ_KEY_VON_NEUMANN_EN
            if (!half) begin
                first = raw;
                half = 1'b1;
            end else begin
                half = 1'b0;
                if (first != raw) begin
                    key = {key[K-2:0], first};
                    nbits++;
                end
            end
`else
            key = {key[K-2:0], raw};
            nbits++;
`endif
            if (nbits == K) return;
        end
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            xs[i] = ($urandom() & 32'h000F_FFFF) | (32'(i) << 20);
            ys[i] = $urandom();
            zs[i] = $urandom();
        end
    endtask

    task automatic fill_directed();
        logic [7:0] pat;
        pat = 8'hB2;
        for (int i = 0; i < DEPTH; i++) begin
            xs[i] = 32'(i) << 1;
            ys[i] = $urandom() & ~32'h1;
            zs[i] = $urandom() & ~32'h1;
        end
        for (int k = 0; k < 8; k++) xs[W - 1 + k * S][0] = pat[7 - k];
    endtask

    task automatic expect_req(input logic [31:0] sg);
        exp_t e;
        bit ie;
        logic [K-1:0] ky;
        model(ie, ky);
        e.is_err = ie;
        e.key = ky;
        e.sigma = sg;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] sg, input logic [31:0] rh, input logic [31:0] bt);
        sigma_in = sg;
        rho_in = rh;
        beta_in = bt;
        start = 1'b1;
        tick();
        start = 1'b0;
        sigma_in = $urandom();
        rho_in = $urandom();
        beta_in = $urandom();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            if (key_valid || err) break;
            tick();
        end
        chk("wait_done", key_valid | err, 1'b1);
    endtask

    task automatic accept_key(input int dly);
        repeat (dly) tick();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk("valid_drop", key_valid, 1'b0);
        chk("busy_drop", busy, 1'b0);
    endtask

    task automatic run_req(input logic [31:0] sg, input int dly);
        expect_req(sg);
        do_start(sg, $urandom(), $urandom());
        wait_done();
        if (key_valid) accept_key(dly);
        else tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_reset"}, core_reset, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_key_valid"}, key_valid, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_key_out"}, key_out, '0);
        chk({tag, "_sigma_out"}, sigma_out, '0);
    endtask

    // Monitor: pops one expectation per key transfer or per error event.
    initial begin
        bit err_prev;
        exp_t e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((key_valid && key_ready) || (err && !err_prev)) begin
                    chk("sb_nonempty", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("resp_kind", {err, key_valid}, {e.is_err, !e.is_err});
                        if (!e.is_err) begin
                            chk("key", key_out, e.key);
                            chk("sigma_latched", sigma_out, e.sigma);
                        end
                    end
                end
            end
            err_prev = err;
        end
    end

    initial begin
        logic [K-1:0] held;
        reset = 1'b1;
        start = 1'b0;
        key_ready = 1'b0;
        sigma_in = '0;
        rho_in = '0;
        beta_in = '0;
        fill_random();
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk_reset_vals("idle");

        fill_directed();
        expect_req(32'd10);
        do_start(32'd10, 32'd28, 32'd3);
        for (int n = 1; n <= 22; n++) begin
            tick();
`ifndef LORENZ_KEY_VON_NEUMANN_EN
            chk($sformatf("core_reset_T%0d", n), core_reset, 1'((n <= 2) || (n >= 22)));
            chk($sformatf("key_valid_T%0d", n), key_valid, 1'(n >= 22));
`endif
            if (n == 4) begin
                start = 1'b1;
                sigma_in = 32'd99;
            end
            if (n == 5) start = 1'b0;
        end
        wait_done();
        chk("sigma_out", sigma_out, 32'd10);
        chk("rho_out", rho_out, 32'd28);
        chk("beta_out", beta_out, 32'd3);
        chk("busy_done", busy, 1'b1);
        held = key_out;
`ifndef LORENZ_KEY_VON_NEUMANN_EN
        chk("key_b2", key_out, 8'hB2);
`endif
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", key_valid, 1'b1);
            chk("hold_key", key_out, held);
        end
        accept_key(0);
        repeat (2) tick();
        chk("key_retained", key_out, held);

        key_ready = 1'b1;
        repeat (2) tick();
        key_ready = 1'b0;
        chk("ready_idle_valid", key_valid, 1'b0);
        chk("ready_idle_busy", busy, 1'b0);

        fill_random();
        xs[W - 1 + 3 * S] = xs[W - 1 + 2 * S];
        ys[W - 1 + 3 * S] = ys[W - 1 + 2 * S];
        zs[W - 1 + 3 * S] = zs[W - 1 + 2 * S];
        expect_req(32'd5);
        do_start(32'd5, 32'd6, 32'd7);
        wait_done();
        chk("stuck_err", err, 1'b1);
        chk("stuck_busy", busy, 1'b0);
        chk("stuck_core_reset", core_reset, 1'b1);
        chk("stuck_valid", key_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stuck_hold_err", err, 1'b1);
            chk("stuck_hold_valid", key_valid, 1'b0);
        end
        fill_random();
        expect_req(32'd77);
        do_start(32'd77, 32'd1, 32'd2);
        chk("err_cleared", err, 1'b0);
        chk("busy_restart", busy, 1'b1);
        wait_done();
        if (key_valid) accept_key(1);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_req($urandom(), $urandom_range(0, 4));
            repeat ($urandom_range(0, 3)) tick();
        end

        fill_random();
        do_start(32'd123, 32'd4, 32'd5);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("midreset");
        tick();
        fill_random();
        run_req(32'd321, 2);

        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lorenz_key_sequencer.md
Name: lorenz_key_sequencer

Overview:
Controller that sequences the Lorenz chaotic core (lorenz_chaos) to produce one key word per request. It latches the system parameters, holds the core in reset, discards a warm-up transient, then harvests one bit per sample from the core's x/y/z outputs into a KEY_WIDTH-bit key. The key is returned over a valid/ready handshake. The block sits between the key-request logic and the chaotic core, and is the only driver of the core's parameter and reset inputs.

Parameters:
KEY_WIDTH, 128, number of key bits per request (>=2)
WARMUP_CYCLES, 1024, core cycles discarded after core reset (>=1)
SAMPLE_STRIDE, 4, core cycles between harvested samples (>=1)
BIT_SEL, 16, bit index of x/y/z used for bit extraction (0..31)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request pulse; accepted only when busy=0
sigma_in  in  32  sigma parameter, latched on accepted start
rho_in  in  32  rho parameter, latched on accepted start
beta_in  in  32  beta parameter, latched on accepted start
x_in  in  32  core x_out
y_in  in  32  core y_out
z_in  in  32  core z_out
sigma_out  out  32  latched sigma to core
rho_out  out  32  latched rho to core
beta_out  out  32  latched beta to core
core_reset  out  1  registered reset to core
busy  out  1  high from accepted start until key transfer or error
key_out  out  KEY_WIDTH  assembled key, stable while key_valid
key_valid  out  1  key available
key_ready  in  1  consumer accepts key
err  out  1  stuck-core error; level output

Behaviour:
- One clock (clk). Reset is synchronous and active-high. Reset values: core_reset=1, busy=0, key_valid=0, err=0, key_out=0, sigma/rho/beta_out=0. State after reset is IDLE.
- FSM states: IDLE, CORE_RST, WARMUP, HARVEST, DONE.
- IDLE: core_reset=1.
  - start=1 -> latch params, clear err, clear key shift register, busy=1, go to CORE_RST.
- CORE_RST: core_reset=1 for exactly 2 cycles. This clears both core register stages. Then go to WARMUP.
- WARMUP: core_reset=0. Count WARMUP_CYCLES cycles, then go to HARVEST.
- HARVEST:
  - Stride counter samples on the first HARVEST cycle and every SAMPLE_STRIDE cycles after.
  - raw bit = x_in[BIT_SEL]^y_in[BIT_SEL]^z_in[BIT_SEL].
  - Shift in at the LSB: key <= {key[KEY_WIDTH-2:0], bit}.
  - After the KEY_WIDTH-th accepted bit, go to DONE. key_valid=1 from the next cycle.
- Timing: start at edge T0 -> core_reset high in T1,T2. WARMUP runs T3..T(2+W). First sample at T(3+W), last at T(3+W)+(K-1)*S. key_valid rises one cycle later.
- DONE: key_valid=1, key_out held, core_reset=1 (core parked).
  - key_valid&&key_ready -> IDLE; key_valid and busy drop the next cycle.
  - key_out retains its value until the next accepted start.
- Stuck check, active in HARVEST on every sample after the first: if {x_in,y_in,z_in} equals the previous sample, then:
  - set err=1, busy=0, key_valid stays 0, core_reset=1;
  - go to IDLE and discard partial bits.
  - err holds until the next accepted start.
- start while busy=1: ignored; latched params do not change.
- reset mid-operation (any state): next cycle shows the reset values and IDLE. A pending key is lost.
- key_ready while key_valid=0: no effect.
- Counters are sized as clog2(param)+1 bits and never wrap within a request.

Optional Feature:
Macro LORENZ_KEY_VON_NEUMANN_EN.
- Defined:
  - Raw bits are paired (first, second); 01 -> emit 0, 10 -> emit 1, 00/11 -> discard the pair.
  - Only emitted bits are shifted in and counted toward KEY_WIDTH, so harvest length varies.
  - The stuck check still applies per sample.
- Undefined: every raw bit is shifted in directly, and latency is exactly as stated above.

Test Plan:
(All with KEY_WIDTH=8, WARMUP_CYCLES=4, SAMPLE_STRIDE=2, BIT_SEL=0, core modelled by the bench.)
- Reset, then idle 5 cycles -> core_reset=1, busy=0, key_valid=0, err=0, key_out=0.
- start at T0 with sigma=10, rho=28, beta=3; bench drives distinct x_in, with bit0 pattern per sample 1,0,1,1,0,0,1,0 and y/z bit0=0 -> core_reset high T1–T2, low T3–T21, key_valid at T22, key_out=8'hB2, sigma_out=10.
- key_ready held 0 for 10 cycles after key_valid -> key_out stays 8'hB2; then key_ready=1 -> key_valid=0 and busy=0 next cycle.
- Second start pulse during WARMUP with sigma_in=99 -> ignored; sigma_out stays 10; timing unchanged.
- Bench repeats an identical x/y/z triple on the 3rd and 4th samples -> err=1, busy=0, core_reset=1, key_valid never asserts; next start clears err.
- reset asserted during HARVEST -> next cycle IDLE, all outputs at reset values; a fresh start completes normally.
